// File: rtl/axis_chk_pkg.sv
// Shared constants for the AXI-Stream counter checker: register offsets,
// FSM encoding, STATUS bit positions and throttle LFSR parameters.
package axis_chk_pkg;

  localparam logic [19:0] REG_CTRL      = 20'h00;
  localparam logic [19:0] REG_PKT_SIZE  = 20'h04;
  localparam logic [19:0] REG_STATUS    = 20'h08;
  localparam logic [19:0] REG_WORD_LO   = 20'h0C;
  localparam logic [19:0] REG_WORD_HI   = 20'h10;
  localparam logic [19:0] REG_PKT_CNT   = 20'h14;
  localparam logic [19:0] REG_ERR_CNT   = 20'h18;
  localparam logic [19:0] REG_EXP_LO    = 20'h1C;
  localparam logic [19:0] REG_EXP_HI    = 20'h20;
  localparam logic [19:0] REG_LAST_LO   = 20'h24;
  localparam logic [19:0] REG_LAST_HI   = 20'h28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int STAT_SEQ  = 0;
  localparam int STAT_LEN  = 1;
  localparam int STAT_KEEP = 2;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axis_chk_lfsr.sv
// Galois LFSR with synchronous load and advance enable; output bit0 is the
// pseudo-random throttle bit.
module axis_chk_lfsr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] taps,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (load)    q <= seed;
    else if (en) q <= (q >> 1) ^ (q[0] ? taps : '0);
  end

endmodule

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink verifying an incrementing counter stream (sequence, tlast
// position, tkeep) with bus-visible counters. Optional AXIS_CHK_THROTTLE_EN
// adds LFSR-driven tready throttling. DATA_W must be a multiple of 8 and <= 64.
module axis_stream_checker
  import axis_chk_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int PKT_DEFAULT = 256
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic [31:0]         sys_addr_i,
  input  logic [31:0]         sys_wdata_i,
  input  logic [3:0]          sys_sel_i,
  input  logic                sys_wen_i,
  input  logic                sys_ren_i,
  output logic [31:0]         sys_rdata_o,
  output logic                sys_ack_o,
  output logic                sys_err_o
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic              en, stop_on_err, sync_first, throttle;
  logic [31:0]       pkt_size;
  state_t            state, state_nxt;
  logic              tready_q, tready_nxt;
  logic [DATA_W-1:0] expected, last_data;
  logic [63:0]       word_cnt;
  logic [31:0]       pkt_cnt, err_cnt, beat_idx;
  logic              seq_flag, len_flag, keep_flag;
  logic [31:0]       rdata_q, rd_val;
  logic              ack_q;

  logic [19:0] addr;
  logic        ctrl_wr, clr, en_new, accept;
  assign addr    = sys_addr_i[19:0];
  assign ctrl_wr = sys_wen_i && (addr == REG_CTRL);
  assign clr     = ctrl_wr && sys_wdata_i[1];
  assign en_new  = ctrl_wr ? sys_wdata_i[0] : en;
  assign accept  = s_axis_tvalid && tready_q;

  assign s_axis_tready = tready_q;
  assign sys_rdata_o   = rdata_q;
  assign sys_ack_o     = ack_q;
  assign sys_err_o     = 1'b0;

  // ---- per-beat checks ----
  logic              sync_skip, at_last, seq_hit, len_hit, keep_hit, any_err;
  logic [DATA_W-1:0] exp_cmp;
  logic [31:0]       last_idx;
  always_comb begin
    sync_skip = (state == ST_ARMED) && sync_first;
    exp_cmp   = (state == ST_ARMED) ? '0 : expected;
    last_idx  = (pkt_size == 32'd0) ? 32'd0 : pkt_size - 32'd1;
    // >= keeps a shrunk PKT_SIZE from letting beat_idx run past the end
    at_last   = beat_idx >= last_idx;
    seq_hit   = accept && !sync_skip && (s_axis_tdata != exp_cmp);
    len_hit   = accept && (s_axis_tlast != at_last);
    keep_hit  = accept && (s_axis_tkeep != '1);
    any_err   = seq_hit || len_hit || keep_hit;
  end

  // ---- FSM ----
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_ARMED;
      ST_ARMED: if (accept) state_nxt = (any_err && stop_on_err) ? ST_HALT : ST_RUN;
      ST_RUN:   if (any_err && stop_on_err) state_nxt = ST_HALT;
      default:  state_nxt = ST_HALT;
    endcase
    if (!en) state_nxt = ST_IDLE;
    if (clr) state_nxt = en_new ? ST_ARMED : ST_IDLE;
  end

  logic gate;
`ifdef AXIS_CHK_THROTTLE_EN
  logic [15:0] lfsr_q;
  axis_chk_lfsr #(.W(16)) u_lfsr (
    .clk  (sys_clk_i),
    .load (sys_rst_i || clr),
    .en   (1'b1),
    .seed (LFSR_SEED),
    .taps (LFSR_TAPS),
    .q    (lfsr_q)
  );
  assign gate = !throttle || lfsr_q[0];
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q[15:1];
`else
  assign gate = 1'b1;
`endif

  // tready follows the next state so it drops in the cycle right after an error
  assign tready_nxt = ((state_nxt == ST_ARMED) || (state_nxt == ST_RUN)) && gate;

  // ---- control, bus response ----
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      en          <= 1'b0;
      stop_on_err <= 1'b0;
      sync_first  <= 1'b0;
      throttle    <= 1'b0;
      pkt_size    <= 32'(PKT_DEFAULT);
      state       <= ST_IDLE;
      tready_q    <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state    <= state_nxt;
      tready_q <= tready_nxt;
      ack_q    <= sys_wen_i || sys_ren_i;
      if (sys_ren_i) rdata_q <= rd_val;
      if (ctrl_wr) begin
        en          <= sys_wdata_i[0];
        stop_on_err <= sys_wdata_i[2];
        sync_first  <= sys_wdata_i[3];
        throttle    <= sys_wdata_i[4];
      end
      if (sys_wen_i && (addr == REG_PKT_SIZE)) pkt_size <= sys_wdata_i;
    end
  end

  // ---- datapath ----
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || clr) begin
      expected  <= '0;
      last_data <= '0;
      word_cnt  <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      beat_idx  <= '0;
      seq_flag  <= 1'b0;
      len_flag  <= 1'b0;
      keep_flag <= 1'b0;
    end else if (accept) begin
      // on a match tdata equals the expected value, so tdata+1 covers both cases
      expected  <= s_axis_tdata + ONE;
      last_data <= s_axis_tdata;
      word_cnt  <= word_cnt + 64'd1;
      if (s_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
      if (any_err && (err_cnt != 32'hFFFF_FFFF)) err_cnt <= err_cnt + 32'd1;
      beat_idx  <= (s_axis_tlast || at_last) ? 32'd0 : beat_idx + 32'd1;
      seq_flag  <= seq_flag  || seq_hit;
      len_flag  <= len_flag  || len_hit;
      keep_flag <= keep_flag || keep_hit;
    end
  end

  // ---- read mux ----
  logic [63:0] exp64, last64;
  always_comb begin
    exp64  = '0;
    last64 = '0;
    exp64[DATA_W-1:0]  = expected;
    last64[DATA_W-1:0] = last_data;
    rd_val = 32'hFFFF_FFFF;
    case (addr)
      REG_CTRL:     rd_val = {27'd0, throttle, sync_first, stop_on_err, 1'b0, en};
      REG_PKT_SIZE: rd_val = pkt_size;
      REG_STATUS:   rd_val = {26'd0, state, 1'b0, keep_flag, len_flag, seq_flag};
      REG_WORD_LO:  rd_val = word_cnt[31:0];
      REG_WORD_HI:  rd_val = word_cnt[63:32];
      REG_PKT_CNT:  rd_val = pkt_cnt;
      REG_ERR_CNT:  rd_val = err_cnt;
      REG_EXP_LO:   rd_val = exp64[31:0];
      REG_EXP_HI:   rd_val = exp64[63:32];
      REG_LAST_LO:  rd_val = last64[31:0];
      REG_LAST_HI:  rd_val = last64[63:32];
      default:      rd_val = 32'hFFFF_FFFF;
    endcase
  end

  logic unused_bus;
  assign unused_bus = ^{sys_sel_i, sys_addr_i[31:20]};

endmodule

// File: tb/tb_axis_stream_checker.sv
// Scoreboard bench for axis_stream_checker: bus reads queue expected values,
// an ack-driven monitor pops and compares them.
module tb_axis_stream_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0, tready, tlast = 1'b0;
  logic [7:0]  tkeep = 8'hFF;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0]  sel = 4'hF;
  logic        wen = 1'b0, ren = 1'b0, ack, err;

  always #5 clk = ~clk;

  axis_stream_checker #(.DATA_W(64), .PKT_DEFAULT(256)) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .s_axis_tdata (tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .s_axis_tlast (tlast),
    .s_axis_tkeep (tkeep),
    .sys_addr_i   (addr),
    .sys_wdata_i  (wdata),
    .sys_sel_i    (sel),
    .sys_wen_i    (wen),
    .sys_ren_i    (ren),
    .sys_rdata_o  (rdata),
    .sys_ack_o    (ack),
    .sys_err_o    (err)
  );

  typedef struct {
    bit          chk;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   stalls = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    sb.push_back('{chk: 1'b0, val: 32'd0, name: "wr"});
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a; ren = 1'b1;
    sb.push_back('{chk: 1'b1, val: exp, name: name});
    tick();
    ren = 1'b0;
    chk({name, "_ack"}, {63'd0, ack}, 64'd1);
  endtask

  task automatic send(input logic [63:0] d, input bit last, input logic [7:0] keep);
    int n = 0;
    tvalid = 1'b1; tdata = d; tlast = last; tkeep = keep;
    while (!tready && n < 100) begin
      stalls++;
      tick();
      n++;
    end
    if (!tready) begin
      checks++; errors++;
      $display("FAIL send_timeout: tready got 0 want 1 for data %0h", d);
    end else begin
      tick();
    end
    tvalid = 1'b0; tlast = 1'b0; tkeep = 8'hFF;
  endtask

  // Monitor: every ack consumes one scoreboard entry; read entries are compared.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (ack) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL stray_ack: got ack want none");
      end else begin
        e = sb.pop_front();
        if (e.chk) begin
          checks++;
          if (rdata !== e.val || err !== 1'b0) begin
            errors++;
            $display("FAIL %s: got %0h (err %0b) want %0h (err 0)", e.name, rdata, err, e.val);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk("rst_tready", {63'd0, tready}, 64'd0);
    chk("rst_ack", {63'd0, ack}, 64'd0);
    rst = 1'b0;
    tick();
    rd(32'h08, 32'h0, "rst_status");
    rd(32'h04, 32'd256, "rst_pkt_size");
    rd(32'h0C, 32'h0, "rst_word_lo");
    rd(32'h00, 32'h0, "rst_ctrl");

    // Sync check: 0..11, tlast on 3/7/11
    wr(32'h04, 32'd4);
    wr(32'h00, 32'h1);
    for (int i = 0; i < 12; i++) send(64'(i), (i % 4) == 3, 8'hFF);
    rd(32'h0C, 32'd12, "sync_word_lo");
    rd(32'h10, 32'd0, "sync_word_hi");
    rd(32'h14, 32'd3, "sync_pkt_cnt");
    rd(32'h08, 32'h20, "sync_status");
    rd(32'h1C, 32'd12, "sync_expected");
    rd(32'h24, 32'd11, "sync_last_data");
    rd(32'h18, 32'd0, "sync_err_cnt");

    // Sequence error: 5 skipped
    wr(32'h00, 32'h3);
    send(64'd0, 0, 8'hFF); send(64'd1, 0, 8'hFF); send(64'd2, 0, 8'hFF); send(64'd3, 1, 8'hFF);
    send(64'd4, 0, 8'hFF); send(64'd6, 0, 8'hFF);
    rd(32'h1C, 32'd7, "seq_expected_resync");
    send(64'd7, 0, 8'hFF); send(64'd8, 1, 8'hFF);
    send(64'd9, 0, 8'hFF); send(64'd10, 0, 8'hFF); send(64'd11, 0, 8'hFF); send(64'd12, 1, 8'hFF);
    rd(32'h08, 32'h21, "seq_status");
    rd(32'h18, 32'd1, "seq_err_cnt");
    rd(32'h1C, 32'd13, "seq_expected_end");
    rd(32'h14, 32'd3, "seq_pkt_cnt");

    // Length error: tlast at index 2 of a 4-beat packet, then PKT_SIZE=0
    wr(32'h00, 32'h3);
    send(64'd0, 0, 8'hFF); send(64'd1, 0, 8'hFF); send(64'd2, 1, 8'hFF);
    for (int i = 3; i < 7; i++) send(64'(i), i == 6, 8'hFF);
    rd(32'h08, 32'h22, "len_status");
    rd(32'h18, 32'd1, "len_err_cnt");
    rd(32'h14, 32'd2, "len_pkt_cnt");
    wr(32'h04, 32'd0);
    for (int i = 7; i < 10; i++) send(64'(i), 1, 8'hFF);
    rd(32'h18, 32'd1, "len0_err_cnt");
    rd(32'h14, 32'd5, "len0_pkt_cnt");
    rd(32'h0C, 32'd10, "len0_word_lo");
    rd(32'h1C, 32'd10, "len0_expected");

    // Halt on bad tkeep
    wr(32'h04, 32'd4);
    wr(32'h00, 32'h7);
    send(64'd0, 0, 8'hFF); send(64'd1, 0, 8'hFF); send(64'd2, 0, 8'h0F);
    chk("halt_tready_next", {63'd0, tready}, 64'd0);
    rd(32'h08, 32'h34, "halt_status");
    rd(32'h18, 32'd1, "halt_err_cnt");
    rd(32'h24, 32'd2, "halt_last_data");
    chk("halt_tready_hold", {63'd0, tready}, 64'd0);
    wr(32'h00, 32'h3);
    rd(32'h0C, 32'd0, "clr_word_lo");
    rd(32'h18, 32'd0, "clr_err_cnt");
    rd(32'h08, 32'h10, "clr_status");
    chk("clr_tready", {63'd0, tready}, 64'd1);

    // Bus: unmapped read, CLR racing an accepted beat
    rd(32'h40, 32'hFFFF_FFFF, "unmapped");
    tvalid = 1'b1; tdata = 64'd0; tlast = 1'b0; tkeep = 8'hFF;
    addr = 32'h00; wdata = 32'h3; wen = 1'b1;
    sb.push_back('{chk: 1'b0, val: 32'd0, name: "wr"});
    tick();
    tvalid = 1'b0; wen = 1'b0;
    rd(32'h0C, 32'd0, "clrbeat_word_lo");
    rd(32'h1C, 32'd0, "clrbeat_expected");

`ifdef AXIS_CHK_THROTTLE_EN
    wr(32'h04, 32'd4);
    wr(32'h00, 32'h13);
    stalls = 0;
    for (int i = 0; i < 1000; i++) send(64'(i), (i % 4) == 3, 8'hFF);
    chk("thr_stalled", {63'd0, stalls > 0}, 64'd1);
    rd(32'h0C, 32'd1000, "thr_word_lo");
    rd(32'h14, 32'd250, "thr_pkt_cnt");
    rd(32'h18, 32'd0, "thr_err_cnt");
    rd(32'h08, 32'h20, "thr_status");
`endif

    begin
      int n = 0;
      while (sb.size() > 0 && n < 20) begin
        tick();
        n++;
      end
      if (sb.size() > 0) begin
        checks++; errors++;
        $display("FAIL drain: got %0d pending acks want 0", sb.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
